// File: rtl/reg_bank_32x_if.sv
// reg_bank_32x_if: write, read-address and observation signals of the 32-entry register bank
interface reg_bank_32x_if #(
  parameter int Q = 32
);
  logic              clr;
  logic              we;
  logic [4:0]        waddr;
  logic [Q-1:0]      wdata;
  logic [4:0]        raddr_a;
  logic [4:0]        raddr_b;
  logic [Q-1:0]      rdata_a;
  logic [Q-1:0]      rdata_b;
  logic [32*Q-1:0]   regs_flat;
  logic [15:0]       wr_count;
  modport master (
    output clr, we, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rdata_b, regs_flat, wr_count
  );
  modport slave (
    input  clr, we, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rdata_b, regs_flat, wr_count
  );
endinterface

// File: rtl/reg_bank_32x.sv
// reg_bank_32x: 32xQ register bank with flat output, two write-first registered read ports and a saturating write counter
module reg_bank_32x #(
  parameter int Q        = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input logic           clk,
  input logic           rstb,
  reg_bank_32x_if.slave bus
);
  logic [Q-1:0] regs_q [32];
  logic [Q-1:0] regs_d [32];
  logic [Q-1:0] rdata_a_q, rdata_a_d;
  logic [Q-1:0] rdata_b_q, rdata_b_d;
  logic [15:0]  wr_count_q, wr_count_d;
  logic         wr_ok;
  assign wr_ok = bus.we && !(ZERO_REG && bus.waddr == 5'd0);
  // regs_d is the post-write view, so indexing it gives the write-first bypass for free
  always_comb begin
    for (int i = 0; i < 32; i++)
      regs_d[i] = (bus.clr || (ZERO_REG && i == 0)) ? '0 :
                  (wr_ok && bus.waddr == 5'(i)) ? bus.wdata : regs_q[i];
    rdata_a_d  = bus.clr ? '0 : regs_d[bus.raddr_a];
    rdata_b_d  = bus.clr ? '0 : regs_d[bus.raddr_b];
    wr_count_d = bus.clr ? 16'd0 :
                 (wr_ok && wr_count_q != 16'hFFFF) ? wr_count_q + 16'd1 : wr_count_q;
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      wr_count_q <= 16'd0;
    end else begin
      for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      wr_count_q <= wr_count_d;
    end
  end
  for (genvar g = 0; g < 32; g++) begin : g_flat
    assign bus.regs_flat[Q*g +: Q] = regs_q[g];
  end
  assign bus.rdata_a  = rdata_a_q;
  assign bus.rdata_b  = rdata_b_q;
  assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_reg_bank_32x.sv
// tb_reg_bank_32x: directed self-checking bench for reg_bank_32x (ZERO_REG=1 and ZERO_REG=0 instances)
module tb_reg_bank_32x;
  logic clk = 1'b0;
  logic rstb = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  reg_bank_32x_if #(.Q(32)) i0 ();
  reg_bank_32x_if #(.Q(32)) i1 ();
  reg_bank_32x #(.Q(32), .ZERO_REG(1'b1)) dut0 (.clk(clk), .rstb(rstb), .bus(i0));
  reg_bank_32x #(.Q(32), .ZERO_REG(1'b0)) dut1 (.clk(clk), .rstb(rstb), .bus(i1));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] sweep_val(input int i);
    return 32'(i) * 32'h01010101;
  endfunction
  initial begin
    i0.clr = 0; i0.we = 1; i0.waddr = 5; i0.wdata = 32'hDEADBEEF; i0.raddr_a = 0; i0.raddr_b = 0;
    i1.clr = 0; i1.we = 0; i1.waddr = 0; i1.wdata = 0;            i1.raddr_a = 0; i1.raddr_b = 0;
    repeat (3) tick;
    check("rst_flat",  64'(|i0.regs_flat), 0);
    check("rst_rda",   i0.rdata_a, 0);
    check("rst_rdb",   i0.rdata_b, 0);
    check("rst_cnt",   i0.wr_count, 0);
    rstb = 1;
    tick;
    check("first_wr_slice5", i0.regs_flat[32*5 +: 32], 32'hDEADBEEF);
    check("first_wr_cnt",    i0.wr_count, 1);
    i0.waddr = 7; i0.wdata = 32'h12345678;
    tick;
    check("lat_slice7",  i0.regs_flat[32*7 +: 32], 32'h12345678);
    check("lat_rda_old", i0.rdata_a, 0);
    i0.we = 0; i0.raddr_a = 7;
    tick;
    check("lat_rda", i0.rdata_a, 32'h12345678);
    i0.we = 1; i0.waddr = 3; i0.wdata = 32'h1;
    tick;
    i0.wdata = 32'hA5A5A5A5; i0.raddr_a = 3; i0.raddr_b = 3;
    tick;
    check("byp_rda", i0.rdata_a, 32'hA5A5A5A5);
    check("byp_rdb", i0.rdata_b, 32'hA5A5A5A5);
    check("byp_cnt", i0.wr_count, 4);
    i0.waddr = 0; i0.wdata = 32'hFFFFFFFF; i0.raddr_a = 0;
    i1.we = 1; i1.waddr = 0; i1.wdata = 32'hFFFFFFFF; i1.raddr_a = 0;
    tick;
    check("z1_rda",    i0.rdata_a, 0);
    check("z1_slice0", i0.regs_flat[31:0], 0);
    check("z1_cnt",    i0.wr_count, 4);
    check("z0_rda",    i1.rdata_a, 32'hFFFFFFFF);
    check("z0_slice0", i1.regs_flat[31:0], 32'hFFFFFFFF);
    check("z0_cnt",    i1.wr_count, 1);
    i1.we = 0;
    for (int i = 1; i < 32; i++) begin
      i0.waddr = 5'(i); i0.wdata = sweep_val(i);
      tick;
    end
    i0.we = 0;
    check("sweep_cnt", i0.wr_count, 35);
    for (int i = 0; i < 32; i++) begin
      i0.raddr_a = 5'(i); i0.raddr_b = 5'(31 - i);
      tick;
      check($sformatf("sweep_a%0d", i), i0.rdata_a, sweep_val(i));
      check($sformatf("sweep_b%0d", 31 - i), i0.rdata_b, sweep_val(31 - i));
    end
    i0.clr = 1; i0.we = 1; i0.waddr = 9; i0.wdata = 32'hCAFEF00D; i0.raddr_a = 9; i0.raddr_b = 4;
    tick;
    check("clr_flat", 64'(|i0.regs_flat), 0);
    check("clr_rda",  i0.rdata_a, 0);
    check("clr_rdb",  i0.rdata_b, 0);
    check("clr_cnt",  i0.wr_count, 0);
    i0.clr = 0; i0.raddr_a = 10; i0.raddr_b = 10;
    for (int i = 10; i < 13; i++) begin
      i0.waddr = 5'(i); i0.wdata = 32'h100 + 32'(i);
      tick;
    end
    check("pre_arst_cnt", i0.wr_count, 3);
    check("pre_arst_rda", i0.rdata_a, 32'h10A);
    #3 rstb = 0;
    #1;
    check("arst_flat", 64'(|i0.regs_flat), 0);
    check("arst_rda",  i0.rdata_a, 0);
    check("arst_rdb",  i0.rdata_b, 0);
    check("arst_cnt",  i0.wr_count, 0);
    check("arst_z0",   i1.regs_flat[31:0], 0);
    tick;
    rstb = 1;
    i0.waddr = 2; i0.wdata = 32'h22;
    repeat (65534) tick;
    check("sat_fffe", i0.wr_count, 16'hFFFE);
    tick;
    check("sat_ffff", i0.wr_count, 16'hFFFF);
    tick;
    check("sat_hold", i0.wr_count, 16'hFFFF);
    check("sat_slice2", i0.regs_flat[32*2 +: 32], 32'h22);
    i0.we = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_bank_32x.md
Name: reg_bank_32x

Overview:
- 32-entry register bank that feeds the 32-to-1 read multiplexers.
- Holds 32 words of Q bits each, and accepts one write per clock.
- Exposes all 32 words as a flat bus for the downstream muxes.
- Also provides two registered read ports with write-first bypass, so the datapath can read operands one cycle after presenting their addresses.

Parameters:
- Q, 32, data width of each register in bits.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and writes to it are ignored; when 0 it is an ordinary register.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rstb  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
- clr  input  1  synchronous clear; on a rising edge with clr=1, all registers and read outputs go to 0.
- we  input  1  write enable.
- waddr  input  5  write register index.
- wdata  input  Q  write data.
- raddr_a  input  5  read port A index.
- raddr_b  input  5  read port B index.
- rdata_a  output  Q  registered read data, port A.
- rdata_b  output  Q  registered read data, port B.
- regs_flat  output  32*Q  all registers concatenated; bits [Q*(i+1)-1 : Q*i] hold register i; feeds the mux select stage.
- wr_count  output  16  number of committed writes since reset/clear.

Behaviour:
- Reset (rstb=0, asynchronous): all 32 registers, rdata_a, rdata_b and wr_count become 0 with no clock edge required.
  - Outputs stay 0 while rstb=0.
  - The first state change occurs on the first rising clk edge with rstb=1.
- Priority at a rising edge: rstb low > clr > write/read.
  - clr=1: registers, rdata_a, rdata_b and wr_count go to 0; any we on that edge is discarded.
- Write commits at the rising edge when we=1 and clr=0.
  - Target is reg[waddr] <= wdata.
  - If ZERO_REG=1 and waddr=0, the write is dropped and wr_count does not increment.
  - Otherwise wr_count increments by 1.
- wr_count saturates at 16'hFFFF and does not wrap.
- regs_flat reflects register contents combinationally from the flops.
  - A committed write is visible on regs_flat immediately after the edge; latency 0 cycles after commit.
  - With ZERO_REG=1, slice 0 is constant 0.
- Read ports have a latency of 1 cycle.
  - At each edge (clr=0), rdata_a <= the value of reg[raddr_a] as it stands after this edge's write.
  - This is write-first bypass: if we=1 and waddr==raddr_a and the write is not dropped, rdata_a <= wdata.
  - Port B is identical using raddr_b.
  - Both ports may address the same register; both get the same value.
- Reading register 0 with ZERO_REG=1 always returns 0, even if written in the same cycle.
- Addresses are always 5 bits, so every index 0..31 is valid; there is no out-of-range case.
- Simultaneous clr and rstb deassertion: reset governs until rstb is sampled high; clr then acts on the next edge.
- rstb asserted mid-operation clears everything immediately.
  - An in-flight write in that cycle is lost.
  - wr_count restarts at 0.
- No X propagation: every flop has a defined reset value.

Test Plan:
- Reset: hold rstb=0, drive we=1 waddr=5 wdata=32'hDEADBEEF for 3 edges -> regs_flat all 0, rdata_a=rdata_b=0, wr_count=0; deassert rstb -> next edge writes reg5, wr_count=1.
- Write/read latency: write reg7=32'h12345678 at edge N, then set raddr_a=7 -> rdata_a=32'h12345678 after edge N+1; regs_flat slice 7 = 32'h12345678 right after edge N.
- Bypass: at one edge set we=1 waddr=3 wdata=32'hA5A5A5A5 with raddr_a=3 and raddr_b=3, previous reg3=32'h1 -> after the edge rdata_a=rdata_b=32'hA5A5A5A5.
- Zero register: with ZERO_REG=1, write waddr=0 wdata=32'hFFFFFFFF and raddr_a=0 -> rdata_a=0, slice 0 = 0, wr_count unchanged; repeat with ZERO_REG=0 -> rdata_a=32'hFFFFFFFF, wr_count +1.
- Sweep and clear: write reg i = i*32'h01010101 for i=1..31, read all via both ports -> values match; then pulse clr=1 alongside we=1 waddr=9 -> after the edge all slices 0, rdata_a=rdata_b=0, wr_count=0.
- Async reset mid-operation: during back-to-back writes, drop rstb between edges -> outputs go to 0 before the next clk edge; wr_count=0.
- Saturation: force 65536 writes to reg 2 -> wr_count holds 16'hFFFF and does not wrap.
